// File: rtl/flash_cmd_seq_if.sv
// rtl/flash_cmd_seq_if.sv - bus bundle between CPU slave port, sequencer and flash cfg port
//
// Groups the Wishbone slave signals (i_wb_*, o_wb_*) and the flash controller
// cfg master signals (o_fl_*, i_fl_*) of flash_cmd_seq.
//   slave  : view taken by flash_cmd_seq (accepts CPU cycles, drives cfg port)
//   master : view taken by the surrounding system (CPU and flash controller)
interface flash_cmd_seq_if;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [1:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_fl_cyc;
    logic        o_fl_stb;
    logic [8:0]  o_fl_data;
    logic        i_fl_stall;
    logic        i_fl_ack;
    logic [7:0]  i_fl_data;

    modport slave (
        input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        output o_wb_stall, o_wb_ack, o_wb_data,
        output o_fl_cyc, o_fl_stb, o_fl_data,
        input  i_fl_stall, i_fl_ack, i_fl_data
    );

    modport master (
        output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
        input  o_wb_stall, o_wb_ack, o_wb_data,
        input  o_fl_cyc, o_fl_stb, o_fl_data,
        output i_fl_stall, i_fl_ack, i_fl_data
    );
endinterface

// File: rtl/flash_cmd_seq.sv
// rtl/flash_cmd_seq.sv - SPI flash command sequencer (WREN/erase/program/RDSR with WIP polling)
//
// Ports:
//   i_clk      system clock
//   i_reset_n  asynchronous active-low reset
//   bus        flash_cmd_seq_if.slave: Wishbone slave (regs 0=CMD/STATUS, 1=ADDR,
//              2=DATA) and flash controller cfg master (o_fl_data[8]=1 sends a
//              byte with CS low, 9'h000 releases CS)
// Parameters:
//   LGTIMEOUT  width of the WIP poll counter; poll abandoned after 2^LGTIMEOUT-1 reads
//   PROT_ADDR  lowest writable byte address when write protection is built in
// Build option:
//   FLASH_CMD_SEQ_WPROT_EN  refuse ERASE/PROG below PROT_ADDR
module flash_cmd_seq #(
    parameter int          LGTIMEOUT = 24,
    parameter logic [23:0] PROT_ADDR = 24'h100000
) (
    input logic            i_clk,
    input logic            i_reset_n,
    flash_cmd_seq_if.slave bus
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_PRE_REL  = 4'd1;
    localparam logic [3:0] S_WREN     = 4'd2;
    localparam logic [3:0] S_WREN_REL = 4'd3;
    localparam logic [3:0] S_CMD      = 4'd4;
    localparam logic [3:0] S_CMD_REL  = 4'd5;
    localparam logic [3:0] S_POLL_CMD = 4'd6;
    localparam logic [3:0] S_POLL_RD  = 4'd7;
    localparam logic [3:0] S_POLL_REL = 4'd8;
    localparam logic [3:0] S_DONE     = 4'd9;

    // Last poll before the counter would saturate.
    localparam logic [LGTIMEOUT-1:0] TMO_LAST = {{(LGTIMEOUT-1){1'b1}}, 1'b0};

    logic [3:0]           state;
    logic [23:0]          addr;
    logic [31:0]          data;
    logic [7:0]           status;
    logic                 err, ovr;
    logic                 need_rel;   // an aborted transfer may have left CS low
    logic                 op_prog, op_rdsr;
    logic [2:0]           byte_idx;
    logic [6:0]           wd;         // cycles waited for the current ack
    logic [LGTIMEOUT-1:0] tmo;

    logic        busy, wb_wr, cmd_wr, wp_block;
    logic [23:0] tx_addr;
    logic [7:0]  cmd_byte;
    logic [8:0]  step_data;
    logic [31:0] rd_mux;

    assign busy   = (state != S_IDLE) && (state != S_DONE);
    assign wb_wr  = bus.i_wb_cyc && bus.i_wb_stb && bus.i_wb_we;
    assign cmd_wr = wb_wr && (bus.i_wb_addr == 2'd0);
    assign bus.o_wb_stall = 1'b0;

`ifdef FLASH_CMD_SEQ_WPROT_EN
    assign wp_block = ((bus.i_wb_data[1:0] == 2'b01) || (bus.i_wb_data[1:0] == 2'b10))
                      && (addr < PROT_ADDR);
`else
    // Protection compiled out: no address is refused.
    assign wp_block = 1'b0 & (addr < PROT_ADDR);
`endif

    always_comb begin
        // Page program works on whole words; erase passes the address through.
        tx_addr = op_prog ? {addr[23:2], 2'b00} : addr;
        cmd_byte = 8'h00;
        case (byte_idx)
            3'd0: cmd_byte = op_prog ? 8'h02 : 8'h20;
            3'd1: cmd_byte = tx_addr[23:16];
            3'd2: cmd_byte = tx_addr[15:8];
            3'd3: cmd_byte = tx_addr[7:0];
            3'd4: cmd_byte = data[31:24];
            3'd5: cmd_byte = data[23:16];
            3'd6: cmd_byte = data[15:8];
            3'd7: cmd_byte = data[7:0];
            default: cmd_byte = 8'h00;
        endcase
        step_data = 9'h000;
        case (state)
            S_WREN:     step_data = 9'h106;
            S_CMD:      step_data = {1'b1, cmd_byte};
            S_POLL_CMD: step_data = 9'h105;
            S_POLL_RD:  step_data = 9'h1FF;
            default:    step_data = 9'h000;
        endcase
        rd_mux = 32'h0;
        case (bus.i_wb_addr)
            2'd0:    rd_mux = {16'h0, status, 4'h0, err, ovr, busy, 1'b0};
            2'd1:    rd_mux = {8'h0, addr};
            2'd2:    rd_mux = data;
            default: rd_mux = 32'h0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state         <= S_IDLE;
            bus.o_wb_ack  <= 1'b0;
            bus.o_wb_data <= 32'h0;
            bus.o_fl_cyc  <= 1'b0;
            bus.o_fl_stb  <= 1'b0;
            bus.o_fl_data <= 9'h000;
            err           <= 1'b0;
            ovr           <= 1'b0;
            status        <= 8'h00;
            addr          <= 24'h0;
            data          <= 32'h0;
            need_rel      <= 1'b0;
            op_prog       <= 1'b0;
            op_rdsr       <= 1'b0;
            byte_idx      <= 3'd0;
            wd            <= 7'd0;
            tmo           <= '0;
        end else begin
            bus.o_wb_ack <= bus.i_wb_stb;
            if (bus.i_wb_stb)
                bus.o_wb_data <= rd_mux;

            // Master side: one transfer in flight; cyc low for one cycle between steps.
            if (bus.o_fl_cyc) begin
                if (bus.o_fl_stb && !bus.i_fl_stall)
                    bus.o_fl_stb <= 1'b0;
                if (bus.i_fl_ack) begin
                    bus.o_fl_cyc <= 1'b0;
                    bus.o_fl_stb <= 1'b0;
                    case (state)
                        S_PRE_REL: begin
                            need_rel <= 1'b0;
                            state    <= op_rdsr ? S_POLL_CMD : S_WREN;
                        end
                        S_WREN:     state <= S_WREN_REL;
                        S_WREN_REL: begin
                            byte_idx <= 3'd0;
                            state    <= S_CMD;
                        end
                        S_CMD: begin
                            if (byte_idx == (op_prog ? 3'd7 : 3'd3))
                                state <= S_CMD_REL;
                            byte_idx <= byte_idx + 3'd1;
                        end
                        S_CMD_REL:  state <= S_POLL_CMD;
                        S_POLL_CMD: state <= S_POLL_RD;
                        S_POLL_RD: begin
                            status <= bus.i_fl_data;
                            state  <= S_POLL_REL;
                        end
                        S_POLL_REL: begin
                            if (op_rdsr || !status[0]) begin
                                state <= S_DONE;
                            end else if (tmo == TMO_LAST) begin
                                tmo   <= tmo + 1'b1;
                                err   <= 1'b1;
                                state <= S_IDLE;
                            end else begin
                                tmo   <= tmo + 1'b1;
                                state <= S_POLL_CMD;
                            end
                        end
                        default: state <= S_IDLE;
                    endcase
                end else if (wd == 7'd127) begin
                    // Controller never answered: give up and deselect on the next op.
                    bus.o_fl_cyc <= 1'b0;
                    bus.o_fl_stb <= 1'b0;
                    err          <= 1'b1;
                    need_rel     <= 1'b1;
                    state        <= S_IDLE;
                end else begin
                    wd <= wd + 7'd1;
                end
            end else if (state == S_DONE) begin
                state <= S_IDLE;
            end else if (state != S_IDLE) begin
                bus.o_fl_cyc  <= 1'b1;
                bus.o_fl_stb  <= 1'b1;
                bus.o_fl_data <= step_data;
                wd            <= 7'd0;
            end

            // Slave register writes; a start here overrides the DONE->IDLE step.
            if (cmd_wr) begin
                if (busy) begin
                    ovr <= 1'b1;
                end else if (bus.i_wb_data[1:0] == 2'b00) begin
                    err <= 1'b0;
                    ovr <= 1'b0;
                end else if (wp_block) begin
                    err <= 1'b1;
                end else begin
                    op_prog <= (bus.i_wb_data[1:0] == 2'b10);
                    op_rdsr <= (bus.i_wb_data[1:0] == 2'b11);
                    tmo     <= '0;
                    if (need_rel)
                        state <= S_PRE_REL;
                    else if (bus.i_wb_data[1:0] == 2'b11)
                        state <= S_POLL_CMD;
                    else
                        state <= S_WREN;
                end
            end else if (wb_wr && !busy && (bus.i_wb_addr == 2'd1)) begin
                addr <= bus.i_wb_data[23:0];
            end else if (wb_wr && !busy && (bus.i_wb_addr == 2'd2)) begin
                data <= bus.i_wb_data;
            end
        end
    end
endmodule

// File: tb/tb_flash_cmd_seq.sv
// tb/tb_flash_cmd_seq.sv - self-checking bench for flash_cmd_seq
module tb_flash_cmd_seq;
    localparam int LGT  = 3;
    localparam int TMAX = (1 << LGT) - 1;

    logic i_clk = 1'b0;
    logic i_reset_n = 1'b0;
    always #5 i_clk = ~i_clk;

    flash_cmd_seq_if fi ();

    flash_cmd_seq #(.LGTIMEOUT(LGT)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (fi)
    );

    int         n_pass = 0;
    int         n_checks = 0;
    logic [8:0] seen[$];
    logic [8:0] exp_q[$];
    int         wip_left = 0;
    logic [7:0] rdsr_val = 8'h00;
    bit         hang = 0;
    int         lat = -1;
    bit         acc = 0;
    logic [8:0] last_byte = 9'h000;

    // Flash controller model: random stall, random ack latency, WIP status source.
    initial begin
        fi.i_fl_stall = 1'b0;
        fi.i_fl_ack   = 1'b0;
        fi.i_fl_data  = 8'h00;
        forever begin
            @(negedge i_clk);
            fi.i_fl_ack = 1'b0;
            if (acc) begin
                last_byte = fi.o_fl_data;
                seen.push_back(fi.o_fl_data);
                lat = $urandom_range(0, 3);
            end
            acc = 0;
            if (lat == 0 && !hang) begin
                fi.i_fl_ack = 1'b1;
                if (last_byte == 9'h1FF) begin
                    if (wip_left > 0) begin
                        fi.i_fl_data = rdsr_val | 8'h01;
                        wip_left = wip_left - 1;
                    end else begin
                        fi.i_fl_data = rdsr_val & 8'hFE;
                    end
                end else begin
                    fi.i_fl_data = 8'($urandom);
                end
                lat = -1;
            end else if (lat > 0) begin
                lat = lat - 1;
            end
            if (fi.o_fl_stb) begin
                fi.i_fl_stall = ($urandom_range(0, 2) == 0);
                acc = !fi.i_fl_stall;
            end else begin
                fi.i_fl_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge i_clk);
        fi.i_wb_cyc = 1'b1; fi.i_wb_stb = 1'b1; fi.i_wb_we = 1'b1;
        fi.i_wb_addr = a;   fi.i_wb_data = d;
        @(negedge i_clk);
        chk("wb_ack_wr", {31'h0, fi.o_wb_ack}, 32'h1);
        fi.i_wb_cyc = 1'b0; fi.i_wb_stb = 1'b0; fi.i_wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge i_clk);
        fi.i_wb_cyc = 1'b1; fi.i_wb_stb = 1'b1; fi.i_wb_we = 1'b0;
        fi.i_wb_addr = a;
        @(negedge i_clk);
        d = fi.o_wb_data;
        fi.i_wb_cyc = 1'b0; fi.i_wb_stb = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        logic [31:0] r;
        bit done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            wb_read(2'd0, r);
            done = !r[1];
        end
        chk({tag, "_finished"}, {31'h0, done}, 32'h1);
    endtask

    // Expected byte stream from the command rules: op 1=erase, 2=prog, 3=rdsr.
    task automatic build_exp(input int op, input logic [23:0] a, input logic [31:0] d,
                             input int wip, input bit pre,
                             output bit e_err, output logic [7:0] e_stat, input logic [7:0] sv);
        int reads;
        int wa;
        exp_q.delete();
        e_err = 0;
        if (pre) exp_q.push_back(9'h000);
        if (op == 3) begin
            reads = 1;
        end else begin
            exp_q.push_back(9'h106);
            exp_q.push_back(9'h000);
            wa = (op == 2) ? (int'(a) / 4) * 4 : int'(a);
            exp_q.push_back((op == 2) ? 9'h102 : 9'h120);
            exp_q.push_back({1'b1, 8'((wa >> 16) & 255)});
            exp_q.push_back({1'b1, 8'((wa >> 8) & 255)});
            exp_q.push_back({1'b1, 8'(wa & 255)});
            if (op == 2)
                for (int k = 3; k >= 0; k--)
                    exp_q.push_back({1'b1, 8'((d >> (8 * k)) & 32'hFF)});
            exp_q.push_back(9'h000);
            reads = wip + 1;
            if (reads > TMAX) begin
                reads = TMAX;
                e_err = 1;
            end
        end
        for (int k = 0; k < reads; k++) begin
            exp_q.push_back(9'h105);
            exp_q.push_back(9'h1FF);
            exp_q.push_back(9'h000);
        end
        e_stat = (wip >= reads) ? (sv | 8'h01) : (sv & 8'hFE);
    endtask

    task automatic check_stream(input string tag);
        int mis = -1;
        chk({tag, "_len"}, seen.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < seen.size(); k++)
            if (mis < 0 && seen[k] !== exp_q[k]) mis = k;
        chk({tag, "_bytes_first_bad_idx"}, mis, -1);
    endtask

    task automatic run_op(input string tag, input int op, input logic [23:0] a,
                          input logic [31:0] d, input int wip, input logic [7:0] sv, input bit pre);
        logic [31:0] r;
        bit          e_err;
        logic [7:0]  e_stat;
        build_exp(op, a, d, wip, pre, e_err, e_stat, sv);
        wb_write(2'd1, {8'h0, a});
        wb_write(2'd2, d);
        seen.delete();
        wip_left = wip;
        rdsr_val = sv;
        wb_write(2'd0, op);
        wait_idle(tag);
        check_stream(tag);
        wb_read(2'd0, r);
        chk({tag, "_err"}, {31'h0, r[3]}, {31'h0, e_err});
        chk({tag, "_busy"}, {31'h0, r[1]}, 32'h0);
        chk({tag, "_status"}, {24'h0, r[15:8]}, {24'h0, e_stat});
        chk({tag, "_cs_released"}, {31'h0, fi.o_fl_cyc}, 32'h0);
        if (e_err) wb_write(2'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] a;
        bit          saw;
        fi.i_wb_cyc = 1'b0; fi.i_wb_stb = 1'b0; fi.i_wb_we = 1'b0;
        fi.i_wb_addr = 2'd0; fi.i_wb_data = 32'h0;
        repeat (3) @(negedge i_clk);
        chk("reset_ctl", {28'h0, fi.o_wb_ack, fi.o_wb_stall, fi.o_fl_cyc, fi.o_fl_stb}, 32'h0);
        chk("reset_fl_data", {23'h0, fi.o_fl_data}, 32'h0);
        chk("reset_wb_data", fi.o_wb_data, 32'h0);
        i_reset_n = 1'b1;
        wb_read(2'd0, r); chk("reset_cmd_reg", r, 32'h0);
        wb_read(2'd1, r); chk("reset_addr_reg", r, 32'h0);
        wb_read(2'd2, r); chk("reset_data_reg", r, 32'h0);

        run_op("erase_wip3", 1, 24'h123456, 32'h0, 3, 8'h40, 0);
        run_op("prog_align", 2, 24'h200007, 32'hDEADBEEF, 0, 8'h00, 0);
        wb_read(2'd1, r); chk("addr_readback", r, 32'h00200007);
        wb_read(2'd2, r); chk("data_readback", r, 32'hDEADBEEF);
        run_op("rdsr_5a", 3, 24'h200007, 32'hDEADBEEF, 0, 8'h5A, 0);

        // Overrun: second command during erase is dropped, ADDR write ignored.
        begin
            bit          e_err;
            logic [7:0]  e_stat;
            build_exp(1, 24'h345678, 32'h0, 2, 0, e_err, e_stat, 8'h00);
            wb_write(2'd1, 32'h345678);
            seen.delete(); wip_left = 2; rdsr_val = 8'h00;
            wb_write(2'd0, 32'h1);
            wb_read(2'd0, r); chk("ovr_busy_set", {31'h0, r[1]}, 32'h1);
            wb_write(2'd0, 32'h2);
            wb_write(2'd1, 32'h777777);
            wait_idle("ovr");
            check_stream("ovr_stream");
            wb_read(2'd0, r); chk("ovr_sticky", {29'h0, r[3:1]}, 32'h2);
            wb_read(2'd1, r); chk("ovr_addr_kept", r, 32'h345678);
            wb_write(2'd0, 32'h0);
            wb_read(2'd0, r); chk("ovr_cleared", {31'h0, r[2]}, 32'h0);
        end

        run_op("timeout_stuck", 1, 24'h400000, 32'h0, 1000, 8'h80, 0);
        run_op("poll_edge_6", 2, 24'h500003, 32'h01234567, TMAX - 1, 8'h02, 0);

        for (int k = 0; k < 6; k++) begin
            a = 24'($urandom);
`ifdef FLASH_CMD_SEQ_WPROT_EN
            a[23] = 1'b1;
`endif
            run_op("random", $urandom_range(1, 3), a, $urandom, $urandom_range(0, TMAX + 1),
                   8'($urandom) & 8'hFE, 0);
        end

        // No ack from the controller: abort, then the next op opens with a CS release.
        hang = 1;
        seen.delete();
        wb_write(2'd0, 32'h3);
        wait_idle("abort");
        wb_read(2'd0, r); chk("abort_err", {31'h0, r[3]}, 32'h1);
        chk("abort_cyc_low", {31'h0, fi.o_fl_cyc}, 32'h0);
        lat = -1;
        hang = 0;
        wb_write(2'd0, 32'h0);
        run_op("after_abort", 3, 24'h000000, 32'h0, 0, 8'h3C, 1);

`ifdef FLASH_CMD_SEQ_WPROT_EN
        seen.delete();
        wb_write(2'd1, 32'h000100);
        wb_write(2'd0, 32'h1);
        chk("wprot_cyc_now", {31'h0, fi.o_fl_cyc}, 32'h0);
        saw = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (fi.o_fl_cyc) saw = 1;
        end
        chk("wprot_no_traffic", {31'h0, saw}, 32'h0);
        wb_read(2'd0, r); chk("wprot_err_not_busy", {29'h0, r[3:1]}, 32'h4);
        wb_write(2'd0, 32'h0);
`else
        run_op("low_addr_erase", 1, 24'h000100, 32'h0, 1, 8'h00, 0);
        saw = 1;
`endif

        // Asynchronous reset in the middle of a program sequence.
        wb_write(2'd1, 32'h600000);
        wb_write(2'd2, 32'hCAFEF00D);
        wb_write(2'd0, 32'h2);
        saw = 0;
        for (int k = 0; k < 50 && !saw; k++) begin
            @(negedge i_clk);
            saw = fi.o_fl_cyc;
        end
        chk("midprog_active", {31'h0, saw}, 32'h1);
        #3 i_reset_n = 1'b0;
        #1;
        chk("midrst_ctl", {29'h0, fi.o_wb_ack, fi.o_fl_cyc, fi.o_fl_stb}, 32'h0);
        chk("midrst_fl_data", {23'h0, fi.o_fl_data}, 32'h0);
        chk("midrst_wb_data", fi.o_wb_data, 32'h0);
        lat = -1; acc = 0; wip_left = 0;
        repeat (3) @(negedge i_clk);
        i_reset_n = 1'b1;
        wb_read(2'd0, r); chk("midrst_cmd_reg", r, 32'h0);
        wb_read(2'd2, r); chk("midrst_data_reg", r, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
